// File: rtl/mem_arbiter.sv
// Multi-channel byte-bus memory arbiter: round-robin grant, little-endian byte
// serialisation, read reassembly, IO back-pressure, bus pause and read abort.
module mem_arbiter #(
  parameter int         NCH   = 2,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH-1:0][1:0]   req_size,
  input  logic [NCH-1:0][31:0]  req_addr,
  input  logic [NCH-1:0][31:0]  req_wdata,
  input  logic [NCH-1:0]        abort_in,
  output logic [NCH-1:0]        req_ready,
  output logic [NCH-1:0]        resp_valid,
  output logic [31:0]           resp_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  last;   // index of final byte: 0, 1 or 3
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t          state, state_nx;
  req_t            cur;
  logic [PW-1:0]   ptr, owner, gnt, cand;
  logic [NCH-1:0]  elig;
  logic            found;
  logic [2:0]      iss;       // next byte to issue (reads may run one past last)
  logic            cap_vld;   // a read byte is due on mem_din this cycle
  logic [1:0]      cap_idx;   // which byte that is
  logic [31:0]     rdata;
  logic [31:0]     byte_a;
  logic            io_stall;
  logic            issue;

  function automatic logic [1:0] last_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;  // 11 is treated as a word
    endcase
  endfunction

  assign elig     = req_valid & ~abort_in;
  assign byte_a   = cur.addr + {29'd0, iss};
  assign io_stall = cur.we && (byte_a[17:16] == IO_HI) && io_buffer_full;

  // Round-robin pick: first eligible channel at or after the pointer.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int o = 0; o < NCH; o++) begin
      cand = PW'((int'(ptr) + o) % NCH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nx;
  end

  // Next state and bus/handshake outputs.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (rdy_in && found && rst_n_in) begin
          req_ready[gnt] = 1'b1;
          state_nx       = XFER;
        end
      end
      XFER: begin
        if (cur.we) begin
          mem_a    = byte_a;
          mem_dout = cur.wdata[{iss[1:0], 3'b000} +: 8];
          mem_wr   = rdy_in && !io_stall;
          if (mem_wr && iss[1:0] == cur.last) state_nx = RESP;
        end else begin
          issue = (iss <= {1'b0, cur.last});
          if (issue) mem_a = byte_a;
          if (rdy_in) begin
            if (abort_in[owner])                         state_nx = IDLE;
            else if (cap_vld && cap_idx == cur.last)     state_nx = RESP;
          end
        end
      end
      RESP: begin
        if (rdy_in) begin
          resp_valid[owner] = 1'b1;
          resp_rdata        = cur.we ? 32'd0 : rdata;
          state_nx          = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, byte counters, read assembly and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr     <= '0;
      owner   <= '0;
      cur     <= '0;
      iss     <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      rdata   <= '0;
    end else if (!rdy_in) begin
      // Data due during a pause is lost: rewind so the byte is re-addressed.
      if (state == XFER && !cur.we && cap_vld) begin
        iss     <= {1'b0, cap_idx};
        cap_vld <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner     <= gnt;
            ptr       <= (gnt == PW'(NCH - 1)) ? '0 : gnt + 1'b1;
            cur.we    <= req_we[gnt];
            cur.last  <= last_of(req_size[gnt]);
            cur.addr  <= req_addr[gnt];
            cur.wdata <= req_wdata[gnt];
            iss       <= '0;
            cap_vld   <= 1'b0;
            rdata     <= '0;
          end
        end
        XFER: begin
          if (cur.we) begin
            if (mem_wr) iss <= iss + 3'd1;
          end else begin
            if (issue) iss <= iss + 3'd1;
            cap_vld <= issue;
            cap_idx <= iss[1:0];
            if (cap_vld) rdata[{cap_idx, 3'b000} +: 8] <= mem_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-memory model on the bus.
module tb_mem_arbiter;
  localparam int NCH = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic                 rdy_in;
  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_we;
  logic [NCH-1:0][1:0]  req_size;
  logic [NCH-1:0][31:0] req_addr;
  logic [NCH-1:0][31:0] req_wdata;
  logic [NCH-1:0]       abort_in;
  logic [NCH-1:0]       req_ready;
  logic [NCH-1:0]       resp_valid;
  logic [31:0]          resp_rdata;
  logic [7:0]           mem_din = 8'h00;
  logic [7:0]           mem_dout;
  logic [31:0]          mem_a;
  logic                 mem_wr;
  logic                 io_buffer_full;

  mem_arbiter #(.NCH(NCH), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .abort_in(abort_in),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] mem [logic [31:0]];
  logic [31:0] la;

  // Byte memory: writes land at the sampled address, read data follows one cycle later.
  always begin
    @(negedge clk_in);
    la = mem_a;
    if (mem_wr) mem[mem_a] = mem_dout;
    @(posedge clk_in);
    #1;
    mem_din = mem.exists(la) ? mem[la] : 8'h00;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp;
    @(negedge clk_in);
  endtask

  task automatic set_req(input logic ch, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid[ch] = 1'b1;
    req_we[ch]    = we;
    req_size[ch]  = sz;
    req_addr[ch]  = a;
    req_wdata[ch] = wd;
  endtask

  logic [1:0] gq [4];
  int ng, cyc;

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; abort_in = '0; io_buffer_full = 1'b0;
    req_valid = 2'b11; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h200] = 8'hFF; mem[32'h201] = 8'h80;
    foreach (gq[i]) gq[i] = 2'b00;

    // Reset state, with requests pending
    nxt; nxt; smp;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    nxt; req_valid = '0; rst_n_in = 1'b1;

    // 4-byte read on ch0
    nxt; set_req(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);
    smp; chk("rd4_gnt", 32'(req_ready), 32'd1);
    nxt; req_valid = '0;
    smp; chk("rd4_a0", mem_a, 32'h100); chk("rd4_wr", 32'(mem_wr), 32'd0);
    for (int i = 1; i < 4; i++) begin
      nxt; smp; chk("rd4_a", mem_a, 32'h100 + 32'(i));
    end
    nxt; smp; chk("rd4_early", 32'(resp_valid), 32'd0);
    nxt; smp; chk("rd4_vld", 32'(resp_valid), 32'd1); chk("rd4_data", resp_rdata, 32'h44332211);
    nxt; smp; chk("rd4_pulse", 32'(resp_valid), 32'd0);

    // Round robin from reset, 1-byte reads
    rst_n_in = 1'b0; #2; rst_n_in = 1'b1;
    nxt;
    set_req(1'b0, 1'b0, 2'b00, 32'h100, 32'd0);
    set_req(1'b1, 1'b0, 2'b00, 32'h101, 32'd0);
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      smp;
      if (req_ready != '0) begin gq[ng] = req_ready; ng++; end
      nxt; cyc++;
    end
    req_valid = '0;
    chk("rr_count", 32'(ng), 32'd4);
    chk("rr_g0", 32'(gq[0]), 32'd1);
    chk("rr_g1", 32'(gq[1]), 32'd2);
    chk("rr_g2", 32'(gq[2]), 32'd1);
    chk("rr_g3", 32'(gq[3]), 32'd2);
    repeat (5) nxt;
    set_req(1'b1, 1'b0, 2'b00, 32'h101, 32'd0);
    smp; chk("lone_ch1", 32'(req_ready), 32'd2);
    nxt; req_valid = '0;
    nxt; nxt; smp;
    chk("lone_vld", 32'(resp_valid), 32'd2); chk("lone_data", resp_rdata, 32'h22);

    // 2-byte read, no sign extension
    nxt; set_req(1'b1, 1'b0, 2'b01, 32'h200, 32'd0);
    smp; chk("rd2_gnt", 32'(req_ready), 32'd2);
    nxt; req_valid = '0;
    nxt; nxt; smp; chk("rd2_early", 32'(resp_valid), 32'd0);
    nxt; smp; chk("rd2_vld", 32'(resp_valid), 32'd2); chk("rd2_data", resp_rdata, 32'h000080FF);

    // IO write with UART back-pressure for three cycles
    nxt; set_req(1'b0, 1'b1, 2'b00, 32'h30000, 32'hAABBCC41); io_buffer_full = 1'b1;
    smp; chk("io_gnt", 32'(req_ready), 32'd1);
    nxt; req_valid = '0;
    smp; chk("io_stall1", 32'(mem_wr), 32'd0);
    nxt; smp; chk("io_stall2", 32'(mem_wr), 32'd0);
    nxt; smp; chk("io_stall3", 32'(mem_wr), 32'd0);
    nxt; io_buffer_full = 1'b0;
    smp; chk("io_wr", 32'(mem_wr), 32'd1); chk("io_dout", 32'(mem_dout), 32'h41);
    chk("io_a", mem_a, 32'h30000);
    nxt; smp; chk("io_resp", 32'(resp_valid), 32'd1); chk("io_rdata", resp_rdata, 32'd0);

    // Abort of a ch1 read during byte 2; a fresh grant follows at once
    nxt; set_req(1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    smp; chk("ab_gnt", 32'(req_ready), 32'd2);
    nxt; req_valid = '0;
    nxt;
    nxt; abort_in = 2'b10;
    smp; chk("ab_a2", mem_a, 32'h102);
    nxt; abort_in = '0; set_req(1'b0, 1'b0, 2'b00, 32'h103, 32'd0);
    smp; chk("ab_idle_gnt", 32'(req_ready), 32'd1); chk("ab_idle_a", mem_a, 32'd0);
    chk("ab_noresp0", 32'(resp_valid), 32'd0);
    nxt; req_valid = '0;
    smp; chk("ab_noresp1", 32'(resp_valid), 32'd0);
    nxt; smp; chk("ab_noresp2", 32'(resp_valid), 32'd0);
    nxt; smp; chk("ab_next_vld", 32'(resp_valid), 32'd1); chk("ab_next_data", resp_rdata, 32'h44);

    // Two-cycle pause mid-read: replay of byte 1, latency 6+3
    nxt; set_req(1'b0, 1'b0, 2'b10, 32'h100, 32'd0);
    smp; chk("pz_gnt", 32'(req_ready), 32'd1);
    nxt; req_valid = '0;
    nxt; smp; chk("pz_a1", mem_a, 32'h101);
    nxt; rdy_in = 1'b0;
    smp; chk("pz_wr", 32'(mem_wr), 32'd0);
    nxt;
    nxt; rdy_in = 1'b1;
    smp; chk("pz_replay", mem_a, 32'h101);
    nxt; nxt; nxt; smp; chk("pz_early", 32'(resp_valid), 32'd0);
    nxt; smp; chk("pz_vld", 32'(resp_valid), 32'd1); chk("pz_data", resp_rdata, 32'h44332211);

    // Async reset in the middle of a word write
    nxt; set_req(1'b0, 1'b1, 2'b10, 32'h400, 32'hDDCCBBAA);
    smp; chk("ar_gnt", 32'(req_ready), 32'd1);
    nxt; req_valid = '0; set_req(1'b1, 1'b0, 2'b00, 32'h100, 32'd0);
    smp; chk("ar_wr0", 32'(mem_wr), 32'd1); chk("ar_dout0", 32'(mem_dout), 32'hAA);
    nxt; #2; rst_n_in = 1'b0; #1;
    chk("ar_wr", 32'(mem_wr), 32'd0); chk("ar_a", mem_a, 32'd0);
    chk("ar_dout", 32'(mem_dout), 32'd0); chk("ar_ready", 32'(req_ready), 32'd0);
    chk("ar_resp", 32'(resp_valid), 32'd0);
    smp;
    chk("ar_byte0", 32'(mem.exists(32'h400) ? mem[32'h400] : 8'h00), 32'hAA);
    chk("ar_byte1", 32'(mem.exists(32'h401)), 32'd0);
    nxt; req_valid = 2'b11; rst_n_in = 1'b1;
    smp; chk("ar_first_gnt", 32'(req_ready), 32'd1);
    nxt; req_valid = '0;
    repeat (6) nxt;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
